// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel word, frame geometry defaults and bank states.
package cnn_pkg;

    localparam int PIX_W_DEF     = 32;
    localparam int FRAME_LEN_DEF = 64;

    typedef enum logic [1:0] {BANK_FREE, BANK_FILL, BANK_FULL} bank_state_t;

    typedef logic signed [PIX_W_DEF-1:0] pix_t;

endpackage

// File: rtl/cnn_img_bank.sv
// One frame buffer with its FREE/FILL/FULL state; storage is never reset.
module cnn_img_bank
    import cnn_pkg::*;
#(
    parameter int  PIX_W     = PIX_W_DEF,
    parameter int  FRAME_LEN = FRAME_LEN_DEF,
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic signed [PIX_W-1:0] wr_data,
    input  logic                    discard,
    input  logic                    complete,
    input  logic                    free_req,
    output logic signed [PIX_W-1:0] img [0:FRAME_LEN-1],
    output logic                    full,
    output logic                    writable
);

    bank_state_t state, state_nxt;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            img[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BANK_FREE;
        end else begin
            state <= state_nxt;
        end
    end

    // A completing beat wins over its own s_last check: long/exact frames still land FULL.
    always_comb begin
        state_nxt = state;
        case (state)
            BANK_FREE: begin
                if (complete) begin
                    state_nxt = BANK_FULL;
                end else if (wr_en && !discard) begin
                    state_nxt = BANK_FILL;
                end
            end
            BANK_FILL: begin
                if (complete) begin
                    state_nxt = BANK_FULL;
                end else if (discard) begin
                    state_nxt = BANK_FREE;
                end
            end
            BANK_FULL: begin
                if (free_req) begin
                    state_nxt = BANK_FREE;
                end
            end
            default: state_nxt = BANK_FREE;
        endcase
    end

    assign full     = (state == BANK_FULL);
    assign writable = (state != BANK_FULL);

endmodule

// File: rtl/cnn_img_loader.sv
// Streaming pixel loader assembling frames for the CNN, with length checking.
// Define CNN_LOADER_PINGPONG_EN for two ping-pong banks; otherwise one bank stalls the stream.
module cnn_img_loader
    import cnn_pkg::*;
#(
    parameter int  PIX_W     = PIX_W_DEF,
    parameter int  FRAME_LEN = FRAME_LEN_DEF,
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [PIX_W-1:0] s_data,
    input  logic                    s_last,
    output logic signed [PIX_W-1:0] img [0:FRAME_LEN-1],
    output logic                    img_valid,
    input  logic                    img_ack,
    output logic                    err_len,
    output logic [15:0]             frame_cnt
);

    logic [IDX_W-1:0] wr_idx;
    logic             rdy_en;
    logic             beat, last_slot, complete, discard, ack;

    assign beat      = s_valid && s_ready;
    assign last_slot = (wr_idx == IDX_W'(FRAME_LEN - 1));
    assign complete  = beat && last_slot;
    assign discard   = beat && s_last && !last_slot;
    assign ack       = img_ack && img_valid;

    // rdy_en keeps s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en    <= 1'b0;
            wr_idx    <= '0;
            err_len   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            rdy_en  <= 1'b1;
            err_len <= discard || (complete && !s_last);
            if (complete) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (complete || discard) begin
                wr_idx <= '0;
            end else if (beat) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
        end
    end

`ifdef CNN_LOADER_PINGPONG_EN
    logic                    wr_bank, rd_bank;
    logic                    full0, full1, wrt0, wrt1;
    logic signed [PIX_W-1:0] img0 [0:FRAME_LEN-1];
    logic signed [PIX_W-1:0] img1 [0:FRAME_LEN-1];

    cnn_img_bank #(.PIX_W(PIX_W), .FRAME_LEN(FRAME_LEN)) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (beat && !wr_bank),
        .wr_idx   (wr_idx),
        .wr_data  (s_data),
        .discard  (discard && !wr_bank),
        .complete (complete && !wr_bank),
        .free_req (ack && !rd_bank),
        .img      (img0),
        .full     (full0),
        .writable (wrt0)
    );

    cnn_img_bank #(.PIX_W(PIX_W), .FRAME_LEN(FRAME_LEN)) u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (beat && wr_bank),
        .wr_idx   (wr_idx),
        .wr_data  (s_data),
        .discard  (discard && wr_bank),
        .complete (complete && wr_bank),
        .free_req (ack && rd_bank),
        .img      (img1),
        .full     (full1),
        .writable (wrt1)
    );

    // Both pointers toggle in lockstep with frame order, so rd_bank always names the oldest FULL bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (complete) begin
                wr_bank <= !wr_bank;
            end
            if (ack) begin
                rd_bank <= !rd_bank;
            end
        end
    end

    assign s_ready   = rdy_en && (wr_bank ? wrt1 : wrt0);
    assign img_valid = rd_bank ? full1 : full0;

    always_comb begin
        for (int k = 0; k < FRAME_LEN; k++) begin
            img[k] = rd_bank ? img1[k] : img0[k];
        end
    end
`else
    logic full0, wrt0;

    cnn_img_bank #(.PIX_W(PIX_W), .FRAME_LEN(FRAME_LEN)) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (beat),
        .wr_idx   (wr_idx),
        .wr_data  (s_data),
        .discard  (discard),
        .complete (complete),
        .free_req (ack),
        .img      (img),
        .full     (full0),
        .writable (wrt0)
    );

    assign s_ready   = rdy_en && wrt0;
    assign img_valid = full0;
`endif

endmodule

// File: tb/tb_cnn_img_loader.sv
// Scoreboard bench for cnn_img_loader: frames and err_len pulses checked by a monitor.
module tb_cnn_img_loader;

    localparam int PIX_W     = 32;
    localparam int FRAME_LEN = 64;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [PIX_W-1:0] s_data;
    logic                    s_last;
    logic signed [PIX_W-1:0] img [0:FRAME_LEN-1];
    logic                    img_valid;
    logic                    img_ack;
    logic                    err_len;
    logic [15:0]             frame_cnt;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int exp_frames[$];
    int exp_errs[$];
    logic ack_taken  = 1'b0;
    logic valid_prev = 1'b0;

    cnn_img_loader #(.PIX_W(PIX_W), .FRAME_LEN(FRAME_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .img       (img),
        .img_valid (img_valid),
        .img_ack   (img_ack),
        .err_len   (err_len),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drive one beat from a negedge; returns at the negedge after it was accepted.
    task automatic send_beat(input int d, input logic last);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && t < 2000) begin
            @(negedge clk);
            t++;
            stalls++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: got 0, want 1 for data %0d", d);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int base, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            send_beat(base + i, i == last_at);
        end
    endtask

    task automatic pulse_ack();
        img_ack = 1'b1;
        @(negedge clk);
        img_ack = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            ack_taken = img_ack && img_valid;
        end
    end

    // Monitor: a frame is newly presented when img_valid rises or stays high across a taken ack.
    initial begin
        int base;
        int bad;
        forever begin
            @(negedge clk);
            if (err_len) begin
                checks++;
                if (exp_errs.size() == 0) begin
                    errors++;
                    $display("FAIL err_len_pulse: got 1, want 0");
                end else begin
                    void'(exp_errs.pop_front());
                end
            end
            if (img_valid && (!valid_prev || ack_taken)) begin
                checks++;
                if (exp_frames.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected: got img[0]=%0d, want no frame", img[0]);
                end else begin
                    base = exp_frames.pop_front();
                    bad  = -1;
                    for (int k = 0; k < FRAME_LEN; k++) begin
                        if (bad < 0 && img[k] !== PIX_W'(base + k)) bad = k;
                    end
                    if (bad >= 0) begin
                        errors++;
                        $display("FAIL frame_%0d img[%0d]: got %0d, want %0d", base, bad, img[bad], base + bad);
                    end
                end
            end
            valid_prev = img_valid;
        end
    end

    initial begin
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        img_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_img_valid", img_valid, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_len", err_len, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("s_ready_after_rst", s_ready, 1);

        exp_frames.push_back(0);
        send_frame(0, 64, 63);
        chk("f0_img_valid", img_valid, 1);
        chk("f0_frame_cnt", frame_cnt, 1);
        chk("f0_img63", img[63], 63);
        pulse_ack();
        chk("f0_ack_img_valid", img_valid, 0);
        chk("f0_ack_s_ready", s_ready, 1);

        pulse_ack();
        chk("idle_ack_img_valid", img_valid, 0);
        chk("idle_ack_frame_cnt", frame_cnt, 1);
        chk("idle_ack_s_ready", s_ready, 1);

        exp_errs.push_back(1);
        send_frame(50, 10, 9);
        chk("short_err_len", err_len, 1);
        chk("short_img_valid", img_valid, 0);
        @(negedge clk);
        chk("short_err_len_off", err_len, 0);
        chk("short_frame_cnt", frame_cnt, 1);

        exp_frames.push_back(300);
        send_frame(300, 64, 63);
        chk("after_short_img_valid", img_valid, 1);
        chk("after_short_frame_cnt", frame_cnt, 2);
        pulse_ack();

        exp_errs.push_back(1);
        exp_frames.push_back(400);
        send_frame(400, 64, -1);
        chk("long_err_len", err_len, 1);
        chk("long_img_valid", img_valid, 1);
        chk("long_frame_cnt", frame_cnt, 3);
        pulse_ack();
        chk("long_ack_img_valid", img_valid, 0);

        exp_frames.push_back(100);
        exp_frames.push_back(200);
        stalls = 0;
`ifdef CNN_LOADER_PINGPONG_EN
        send_frame(100, 64, 63);
        send_frame(200, 64, 63);
        chk("pp_no_stall", stalls, 0);
        chk("pp_s_ready_full", s_ready, 0);
        chk("pp_img_valid", img_valid, 1);
        chk("pp_show_a", img[0], 100);
        chk("pp_frame_cnt", frame_cnt, 5);
        pulse_ack();
        chk("pp_valid_held", img_valid, 1);
        chk("pp_show_b", img[5], 205);
        chk("pp_s_ready_freed", s_ready, 1);
        pulse_ack();
        chk("pp_b_ack_img_valid", img_valid, 0);

        exp_frames.push_back(500);
        send_frame(500, 64, 63);
        exp_frames.push_back(600);
        fork
            send_frame(600, 64, 63);
            begin
                repeat (63) @(negedge clk);
                pulse_ack();
            end
        join
        chk("sim_img_valid", img_valid, 1);
        chk("sim_show_d", img[63], 663);
        chk("sim_frame_cnt", frame_cnt, 7);
        chk("sim_s_ready", s_ready, 1);
        pulse_ack();
        chk("sim_end_img_valid", img_valid, 0);
`else
        send_frame(100, 64, 63);
        chk("sb_s_ready_full", s_ready, 0);
        chk("sb_img_valid", img_valid, 1);
        chk("sb_frame_cnt_a", frame_cnt, 4);
        fork
            send_frame(200, 64, 63);
            begin
                repeat (4) @(negedge clk);
                chk("sb_stalled_s_ready", s_ready, 0);
                chk("sb_still_a", img[0], 100);
                chk("sb_frame_cnt_hold", frame_cnt, 4);
                pulse_ack();
            end
        join
        chk("sb_b_waited", stalls > 0, 1);
        chk("sb_b_img_valid", img_valid, 1);
        chk("sb_frame_cnt_b", frame_cnt, 5);
        chk("sb_b_s_ready", s_ready, 0);
        pulse_ack();
        chk("sb_b_ack_img_valid", img_valid, 0);
        chk("sb_b_ack_s_ready", s_ready, 1);

        exp_frames.push_back(500);
        send_frame(500, 64, 63);
        chk("sb_c_frame_cnt", frame_cnt, 6);
        pulse_ack();
        chk("sb_c_ack_img_valid", img_valid, 0);
`endif

        repeat (3) @(negedge clk);
        chk("frames_pending", exp_frames.size(), 0);
        chk("errs_pending", exp_errs.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_img_loader.md
# cnn_img_loader

Streaming input stage placed directly upstream of the CNN top level (conv -> pool -> fc). It accepts 32-bit pixels over a valid/ready stream and assembles complete 8x8 frames of 64 words in row-major order. Each complete frame is presented as a stable 64-word image array with a level `img_valid`. A bank is freed only when the consumer acknowledges the frame, so the next frame can load while the current one is being processed.

## Interface
Parameters:
- `PIX_W`, default 32: pixel word width.
- `FRAME_LEN`, default 64: words per frame. It must be a power of two, and the index is `$clog2(FRAME_LEN)` bits wide.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low. Asserting it clears all state immediately.
- `s_valid`  in  1: upstream pixel valid.
- `s_ready`  out  1: loader can accept a pixel.
- `s_data`  in  PIX_W: pixel, signed two's complement.
- `s_last`  in  1: marks the final pixel of a frame.
- `img`  out  PIX_W x [0:FRAME_LEN-1]: presented frame, unpacked array. Index 0 is the first pixel received.
- `img_valid`  out  1: `img` holds a complete frame. Held high until acknowledged.
- `img_ack`  in  1: one-cycle pulse from the consumer meaning it has finished with `img`.
- `err_len`  out  1: one-cycle pulse when a frame is received with the wrong length.
- `frame_cnt`  out  16: count of frames presented. Wraps at 65535 -> 0.

## Operation
- A pixel is transferred on any cycle where `s_valid && s_ready`. It is written to `bank[wr_bank][wr_idx]`, and then `wr_idx` increments.
- Each bank holds one of three states:
  - FREE -> FILL on the first accepted beat.
  - FILL -> FULL when the beat with `wr_idx==FRAME_LEN-1` is accepted.
  - FULL -> FREE on `img_ack` while that bank is presented.
- Length check:
  - Short frame (`s_last` set with `wr_idx!=FRAME_LEN-1`): pulse `err_len`, discard the partial frame, reset `wr_idx` to 0, and leave the bank FREE.
  - Long frame (the last slot is filled with `s_last` low): pulse `err_len` but still mark the bank FULL. Subsequent beats start the next frame.
- Presentation:
  - The read-select `rd_bank` points at the oldest FULL bank.
  - `img = bank[rd_bank]`, and `img_valid` is high iff that bank is FULL.
  - When the presented frame is acknowledged, `rd_bank` toggles to the other bank; if that bank is not FULL, `img_valid` goes low.
  - Frames are presented strictly in arrival order.
- `frame_cnt` increments on each FILL->FULL transition.
- `img_ack` while `img_valid` is low is ignored.
- `s_ready` is high iff `bank[wr_bank]` is FREE or FILL.
- On the FULL transition, `wr_bank` toggles.
- If `img_ack` and the completing beat occur in the same cycle, both take effect:
  - The acked bank becomes FREE.
  - The other bank becomes FULL and is presented on the next cycle.
  - `s_ready` on the next cycle reflects the newly freed bank.
- While `rst` is low:
  - Both banks are FREE, `wr_bank=rd_bank=0`, and `wr_idx=0`.
  - Outputs: `s_ready=0`, `img_valid=0`, `err_len=0`, `frame_cnt=0`.
  - Bank contents are not reset; `img` reads X/stale and is don't-care while `img_valid` is low.
  - Reset mid-frame discards the partial frame and any FULL frames.
- `s_ready` rises on the first clock edge after reset deasserts.

## Timing
- Accepts one pixel per cycle at full throughput as long as a bank is writable.
- Latency from the accepted last beat to `img_valid` high is 1 cycle, because the state register is updated on that edge.
- `img_valid` falls on the cycle after `img_ack`, unless the other bank is FULL, in which case it stays high and `img` switches on that same edge.
- `img` is stable for the entire time `img_valid` is high, since the presented bank is never written.
- `err_len` asserts in the cycle after the offending beat, for exactly 1 cycle.
- `s_ready` is registered: it is a function of bank state only, with no combinational path from `s_valid`.

## Configuration
- `CNN_LOADER_PINGPONG_EN` defined: two banks, operating as above.
- Undefined: one bank.
  - `wr_bank` and `rd_bank` are fixed at 0.
  - `s_ready` is low from FULL until the cycle after `img_ack`.
  - Streaming stalls while the CNN runs.
  - All other behaviour is unchanged.

## Structure
- Shared package `cnn_pkg` holds:
  - `PIX_W` and `FRAME_LEN` defaults;
  - `typedef enum logic [1:0] {BANK_FREE, BANK_FILL, BANK_FULL} bank_state_t`;
  - the pixel typedef `pix_t`, shared with conv/pool/fc.
- One natural sub-module, `cnn_img_bank`, holding one frame:
  - storage with write enable and index;
  - its state register;
  - full/free outputs.
- Instantiate it once or twice depending on the macro. The top-level mux and pointers live in `cnn_img_loader`.

## Test plan
- **Reset:** hold `rst=0` for 3 cycles, then release. Require `s_ready=0`, `img_valid=0`, `frame_cnt=0` during reset, and `s_ready=1` on the next edge after release.
- **Single frame:** send 64 beats with data 0..63 and `s_last` on the 64th beat. Require `img_valid=1` one cycle later, `img[k]==k` for all k, and `frame_cnt=1`. Pulse `img_ack` -> `img_valid=0` next cycle.
- **Ping-pong (macro on):** send frames A (data 100+k) and B (data 200+k) back-to-back with no ack.
  - Require `s_ready` to stay high through all 128 beats, then drop until an ack.
  - Require `img` to show A; after `img_ack`, `img` shows B with `img_valid` continuously high.
- **Single bank (macro off):** same stimulus as the ping-pong test. Require `s_ready=0` after beat 64, and B starts only after `img_ack`.
- **Length errors:**
  - `s_last` on beat 10 -> `err_len` 1-cycle pulse, no `img_valid`, and the next 64-beat frame loads correctly.
  - 64 beats without `s_last` -> `err_len` pulse and `img_valid=1`.
- **Simultaneous events:** `img_ack` coincides with the 64th beat of the next frame. Require the next frame to be presented the following cycle, `frame_cnt` incremented, and no lost or duplicated frame. Also drive `img_ack` with `img_valid=0` and require no state change.
